// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/DVI raster timing with pixel enable,
// configurable output delay and line/frame start strobes.
module vga_timing_gen #(
    parameter int H_ACTIVE = 1440,
    parameter int H_FP     = 80,
    parameter int H_SYNC   = 152,
    parameter int H_BP     = 232,
    parameter int V_ACTIVE = 900,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 28,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b1,
    parameter int PIPE_DLY = 0,
    parameter int HW       = 12,
    parameter int VW       = 11
) (
    input  logic          vga_pclk,
    input  logic          vga_rst_n,
    input  logic          vga_ce,
    output logic          vga_hsync,
    output logic          vga_vsync,
    output logic          vga_valid,
    output logic [HW-1:0] vga_h_cnt,
    output logic [VW-1:0] vga_v_cnt,
    output logic          vga_line_start,
    output logic          vga_frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int W = HW + VW + 5;
    localparam logic [W-1:0] IDLE = {~HS_POL, ~VS_POL, {(W-2){1'b0}}};

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [W-1:0]  pipe_q [0:PIPE_DLY];
    logic [W-1:0]  pipe_d [0:PIPE_DLY];
    logic          h_last, v_last, valid, hs_act, vs_act;
    logic [W-1:0]  dec;

    always_comb begin
        h_last = h_q == HW'(H_TOTAL - 1);
        v_last = v_q == VW'(V_TOTAL - 1);
        valid  = h_q < HW'(H_ACTIVE) && v_q < VW'(V_ACTIVE);
        hs_act = h_q >= HW'(H_ACTIVE + H_FP) && h_q < HW'(H_ACTIVE + H_FP + H_SYNC);
        vs_act = v_q >= VW'(V_ACTIVE + V_FP) && v_q < VW'(V_ACTIVE + V_FP + V_SYNC);
        dec = {hs_act ? HS_POL : ~HS_POL, vs_act ? VS_POL : ~VS_POL, valid,
               valid ? h_q : '0, valid ? v_q : '0, h_q == '0, h_q == '0 && v_q == '0};
        h_d    = h_q;
        v_d    = v_q;
        pipe_d = pipe_q;
        if (vga_ce) begin
            h_d = h_last ? '0 : h_q + 1'b1;
            v_d = h_last ? (v_last ? '0 : v_q + 1'b1) : v_q;
            pipe_d[0] = dec;
            for (int i = 1; i <= PIPE_DLY; i++) pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge vga_pclk) begin
        if (!vga_rst_n) begin
            h_q <= '0;
            v_q <= '0;
            for (int i = 0; i <= PIPE_DLY; i++) pipe_q[i] <= IDLE;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            pipe_q <= pipe_d;
        end
    end

    // Last stage is itself a register, so outputs are glitch-free and skew-free.
    assign {vga_hsync, vga_vsync, vga_valid, vga_h_cnt, vga_v_cnt,
            vga_line_start, vga_frame_start} = pipe_q[PIPE_DLY];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random pixel-enable/reset stimulus against a raster-index model
// for a small undelayed, small delayed and default-sized instance.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;
    int   n = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    typedef struct {
        int hs, vs, vl, hc, vc, ls, fs;
    } exp_t;

    logic       a_hs, a_vs, a_vl, a_ls, a_fs;
    logic [4:0] a_hc;
    logic [3:0] a_vc;
    logic       b_hs, b_vs, b_vl, b_ls, b_fs;
    logic [4:0] b_hc;
    logic [3:0] b_vc;
    logic        d_hs, d_vs, d_vl, d_ls, d_fs;
    logic [11:0] d_hc;
    logic [10:0] d_vc;

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_DLY(0), .HW(5), .VW(4)) dut_a (
        .vga_pclk(clk), .vga_rst_n(rst_n), .vga_ce(ce), .vga_hsync(a_hs), .vga_vsync(a_vs),
        .vga_valid(a_vl), .vga_h_cnt(a_hc), .vga_v_cnt(a_vc), .vga_line_start(a_ls),
        .vga_frame_start(a_fs));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_DLY(3), .HW(5), .VW(4)) dut_b (
        .vga_pclk(clk), .vga_rst_n(rst_n), .vga_ce(ce), .vga_hsync(b_hs), .vga_vsync(b_vs),
        .vga_valid(b_vl), .vga_h_cnt(b_hc), .vga_v_cnt(b_vc), .vga_line_start(b_ls),
        .vga_frame_start(b_fs));

    vga_timing_gen dut_d (
        .vga_pclk(clk), .vga_rst_n(rst_n), .vga_ce(ce), .vga_hsync(d_hs), .vga_vsync(d_vs),
        .vga_valid(d_vl), .vga_h_cnt(d_hc), .vga_v_cnt(d_vc), .vga_line_start(d_ls),
        .vga_frame_start(d_fs));

    // Expected outputs for raster position index k; negative k means idle.
    function automatic exp_t model(int k, int ha, int hf, int hsw, int hb, int va, int vf,
                                   int vsw, int vb, int hp, int vp);
        exp_t e;
        int ht, vt, h, v;
        e = '{hs: 1 - hp, vs: 1 - vp, vl: 0, hc: 0, vc: 0, ls: 0, fs: 0};
        if (k < 0) return e;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        h = k % ht;
        v = (k / ht) % vt;
        e.vl = int'(h < ha && v < va);
        e.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : 1 - hp;
        e.vs = (v >= va + vf && v < va + vf + vsw) ? vp : 1 - vp;
        e.hc = e.vl ? h : 0;
        e.vc = e.vl ? v : 0;
        e.ls = int'(h == 0);
        e.fs = int'(h == 0 && v == 0);
        return e;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got %0d expected %0d", tag, n, got, exp);
        end
    endtask

    task automatic check_all();
        exp_t e;
        e = model(n - 1, 8, 2, 3, 3, 4, 1, 2, 1, 0, 1);
        check("a.hsync", int'(a_hs), e.hs); check("a.vsync", int'(a_vs), e.vs);
        check("a.valid", int'(a_vl), e.vl); check("a.h_cnt", int'(a_hc), e.hc);
        check("a.v_cnt", int'(a_vc), e.vc); check("a.line_start", int'(a_ls), e.ls);
        check("a.frame_start", int'(a_fs), e.fs);
        e = model(n - 4, 8, 2, 3, 3, 4, 1, 2, 1, 0, 1);
        check("b.hsync", int'(b_hs), e.hs); check("b.vsync", int'(b_vs), e.vs);
        check("b.valid", int'(b_vl), e.vl); check("b.h_cnt", int'(b_hc), e.hc);
        check("b.v_cnt", int'(b_vc), e.vc); check("b.line_start", int'(b_ls), e.ls);
        check("b.frame_start", int'(b_fs), e.fs);
        e = model(n - 1, 1440, 80, 152, 232, 900, 1, 3, 28, 0, 1);
        check("d.hsync", int'(d_hs), e.hs); check("d.vsync", int'(d_vs), e.vs);
        check("d.valid", int'(d_vl), e.vl); check("d.h_cnt", int'(d_hc), e.hc);
        check("d.v_cnt", int'(d_vc), e.vc); check("d.line_start", int'(d_ls), e.ls);
        check("d.frame_start", int'(d_fs), e.fs);
    endtask

    task automatic step(input logic r, input logic c);
        rst_n = r;
        ce = c;
        @(posedge clk);
        if (!r) n = 0;
        else if (c) n++;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 600; i++) step(1'b1, (i % 4 == 0) || (i % 4 == 3));
        step(1'b0, 1'b1);
        while (n < 37) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 4500; i++)
            step(($urandom % 700) != 0, ($urandom % 4) != 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/DVI raster timing generator; next generation of the fixed 1440x900 timing block.
- Generalised in resolution, porch and sync widths, sync polarity and counter width.
- Adds a pixel clock-enable, a configurable output pipeline delay for alignment with downstream pixel pipelines, and line-start / frame-start strobes.
- Sits between the pixel clock domain and the pixel-generation / video-out logic; one instance per display head.

Parameters:
- H_ACTIVE, 1440, visible pixels per line
- H_FP, 80, horizontal front porch (pixels)
- H_SYNC, 152, hsync width (pixels)
- H_BP, 232, horizontal back porch (pixels)
- V_ACTIVE, 900, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vsync width (lines)
- V_BP, 28, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low, 1 = active-high)
- VS_POL, 1, vsync active level
- PIPE_DLY, 0, extra output register stages, 0..15
- HW, 12, horizontal counter width; must hold H_TOTAL-1
- VW, 11, vertical counter width; must hold V_TOTAL-1

Ports:
- vga_pclk  in  1  pixel clock; all logic on its rising edge
- vga_rst_n  in  1  synchronous active-low reset
- vga_ce  in  1  pixel enable; state advances only on edges where vga_ce=1
- vga_hsync  out  1  horizontal sync, polarity per HS_POL
- vga_vsync  out  1  vertical sync, polarity per VS_POL
- vga_valid  out  1  high for pixels inside the active area
- vga_h_cnt  out  HW  active-area x coordinate; 0 when not valid
- vga_v_cnt  out  VW  active-area y coordinate; 0 when not valid
- vga_line_start  out  1  one-enabled-cycle strobe at h=0 of every line (active and blanking)
- vga_frame_start  out  1  one-enabled-cycle strobe at h=0, v=0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Every timing parameter is at least 1.
- Internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1).
  - h increments on each enabled edge and wraps to 0 after H_TOTAL-1.
  - v increments when h wraps, and wraps to 0 after V_TOTAL-1.
  - Both wrap on the same edge at frame end (H_TOTAL-1, V_TOTAL-1 -> 0, 0).
- Decode of position (h, v):
  - valid = h<H_ACTIVE && v<V_ACTIVE.
  - hsync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync active for whole lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; it changes only when h=0.
  - line_start = (h==0); frame_start = (h==0 && v==0).
  - h_cnt/v_cnt equal h/v when valid, otherwise 0.
- Output pipeline: on each enabled edge, the decode of the current (h, v) enters stage 1, then the counters advance.
  - Stages 2..PIPE_DLY+1 shift on enabled edges only.
  - All outputs come registered from the last stage.
  - After the n-th enabled edge following reset, outputs describe position index n-1-PIPE_DLY (raster order from (0,0)). Before that, outputs hold the idle value.
  - All outputs move together; there is no inter-output skew.
- Idle / reset value, applied on any edge with vga_rst_n=0 regardless of vga_ce:
  - h = v = 0; every pipeline stage is idle.
  - hsync = ~HS_POL; vsync = ~VS_POL.
  - valid = 0; h_cnt = v_cnt = 0; line_start = frame_start = 0.
- vga_ce=0: counters, pipeline and outputs hold. Strobes therefore stay high for as many clocks as vga_ce stays low; consumers qualify strobes with vga_ce.
- Reset mid-frame: the next frame restarts cleanly from (0,0) with no partial strobes.

Test Plan:
- Small timing (H 8/2/3/3, V 4/1/2/1, PIPE_DLY=0, vga_ce=1), reset released -> after edge 1: frame_start=1, line_start=1, valid=1, h_cnt=0. Strobe period is 16 clocks; frame period is 128 clocks.
- Same config, hsync check -> hsync low while output position h=10..12 (3 clocks per line). vsync high (VS_POL=1) for lines v=5..6 (32 clocks), rising exactly together with line_start. valid=1 for exactly 32 clocks per frame.
- Defaults (1440x900) -> line period 1904, frame period 1774528 clocks. hsync low for h=1520..1671. vsync active for v=901..903. Last valid pixel has h_cnt=1439, v_cnt=899; h_cnt/v_cnt are 0 in blanking.
- PIPE_DLY=3 vs PIPE_DLY=0, run side by side -> every output of the delayed instance equals the undelayed one 3 clocks earlier. Outputs stay at idle for the first 3 edges after reset.
- vga_ce toggling 1,0,0,1 repeating -> output sequence identical to a vga_ce=1 run, sampled only on enabled edges. Outputs never change on a vga_ce=0 edge.
- Assert vga_rst_n=0 for 1 clock at h=5, v=2 (small config), vga_ce=0 during reset -> idle values on the next edge. After release, the first enabled edge yields frame_start=1 at (0,0).
